// File: rtl/phat_chuoi_serial_tx.sv
// phat_chuoi_serial_tx: repeating MSB-first serial frame transmitter with idle-zero gaps
module phat_chuoi_serial_tx #(
    parameter int DATA_W  = 4,
    parameter int GAP_LEN = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        rep,
    output logic              w,
    output logic              bit_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] hold_reg;
    logic [3:0]        bit_idx;
    logic [3:0]        gap_cnt;
    logic [3:0]        rep_left;

    assign busy = state != IDLE;

    // frame sequencer: sreg holds the bits still to send, w is loaded one edge ahead
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state     <= IDLE;
            sreg      <= '0;
            hold_reg  <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            rep_left  <= '0;
            w         <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !done) begin
                    sreg      <= data_in << 1;
                    hold_reg  <= data_in;
                    rep_left  <= rep;
                    w         <= data_in[DATA_W-1];
                    bit_valid <= 1'b1;
                    bit_idx   <= 4'(DATA_W - 1);
                    state     <= SHIFT;
                end
            end else if (state == SHIFT) begin
                if (bit_idx == 4'd0) begin
                    w         <= 1'b0;
                    bit_valid <= 1'b0;
                    gap_cnt   <= 4'(GAP_LEN - 1);
                    frame_cnt <= frame_cnt + CNT_W'(1);
                    state     <= GAP;
                end else begin
                    w       <= sreg[DATA_W-1];
                    sreg    <= sreg << 1;
                    bit_idx <= bit_idx - 4'd1;
                end
            end else if (state == GAP) begin
                if (gap_cnt != 4'd0) begin
                    gap_cnt <= gap_cnt - 4'd1;
                end else if (rep_left != 4'd0) begin
                    rep_left  <= rep_left - 4'd1;
                    sreg      <= hold_reg << 1;
                    w         <= hold_reg[DATA_W-1];
                    bit_valid <= 1'b1;
                    bit_idx   <= 4'(DATA_W - 1);
                    state     <= SHIFT;
                end else begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_phat_chuoi_serial_tx.sv
// tb_phat_chuoi_serial_tx: cycle-level model check plus directed literal checks
module tb_phat_chuoi_serial_tx;
    localparam int DW = 4;
    localparam int GL = 1;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rs = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [3:0]    rep = '0;
    logic          w, bit_valid, busy, done;
    logic [CW-1:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    phat_chuoi_serial_tx #(.DATA_W(DW), .GAP_LEN(GL), .CNT_W(CW)) dut (
        .clk(clk), .rs(rs), .start(start), .data_in(data_in), .rep(rep),
        .w(w), .bit_valid(bit_valid), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic w;
        logic v;
        logic b;
        logic d;
        logic fe;
    } ent_t;

    ent_t          q[$];
    ent_t          cur = '0;
    logic [CW-1:0] mcnt = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: each accepted start expands into the full per-cycle output sequence
    initial forever begin
        @(posedge clk or negedge rs);
        if (!rs) begin
            q.delete();
            cur = '0;
            mcnt = '0;
        end else begin
            if (q.size() == 0 && start && !cur.d) begin
                for (int r = 0; r <= int'(rep); r++) begin
                    for (int i = DW - 1; i >= 0; i--) q.push_back({data_in[i], 4'b1100});
                    for (int g = 0; g < GL; g++) q.push_back({3'b001, 1'b0, 1'(g == 0)});
                end
                q.push_back(5'b00010);
            end
            cur = (q.size() != 0) ? q.pop_front() : '0;
            if (cur.fe) mcnt = mcnt + 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("w", int'(w), int'(cur.w));
        chk("bit_valid", int'(bit_valid), int'(cur.v));
        chk("busy", int'(busy), int'(cur.b));
        chk("done", int'(done), int'(cur.d));
        chk("frame_cnt", int'(frame_cnt), int'(mcnt));
    end

    logic [63:0] ws, vs;
    int          n;

    task automatic send(input logic [3:0] d, input logic [3:0] r, input bit glitch);
        @(posedge clk); #1;
        data_in = d; rep = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ws = '0; vs = '0; n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            ws = {ws[62:0], w};
            vs = {vs[62:0], bit_valid};
            n++;
            if (glitch && k == 1) begin start = 1'b1; data_in = 4'b0000; end
            if (glitch && k == 2) start = 1'b0;
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rs = 1'b1;
        chk("reset_cnt", int'(frame_cnt), 0);
        @(posedge clk); #1;
        data_in = 4'b1111; rep = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rs = 1'b0;
        @(negedge clk);
        chk("abort_w", int'(w), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cnt", int'(frame_cnt), 0);
        @(posedge clk); #1;
        rs = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", int'(done), 0);

        send(4'b1111, 4'd0, 1'b0);
        chk("s2_len", n, 6);
        chk("s2_w", int'(ws[5:0]), 6'b111100);
        chk("s2_valid", int'(vs[5:0]), 6'b111100);
        chk("s2_cnt", int'(frame_cnt), 1);

        send(4'b1111, 4'd1, 1'b0);
        chk("s3_len", n, 11);
        chk("s3_w", int'(ws[10:0]), 11'b11110111100);
        chk("s3_cnt", int'(frame_cnt), 3);

        send(4'b1010, 4'd0, 1'b0);
        chk("s4_w", int'(ws[5:0]), 6'b101000);
        chk("s4_valid", int'(vs[5:0]), 6'b111100);

        send(4'b1111, 4'd0, 1'b1);
        chk("s5_w", int'(ws[5:0]), 6'b111100);
        chk("s5_cnt", int'(frame_cnt), 5);

        start = 1'b1;
        @(negedge clk);
        chk("done_cycle_start_busy", int'(busy), 0);
        chk("done_cycle_start_valid", int'(bit_valid), 0);
        start = 1'b0;

        @(posedge clk); #1;
        rs = 1'b0;
        @(posedge clk); #1;
        rs = 1'b1;
        for (int s = 0; s < 16; s++) send(4'b1011, 4'd15, 1'b0);
        chk("s6_wrap", int'(frame_cnt), 0);
        send(4'b1001, 4'd0, 1'b0);
        chk("s6_next_len", n, 6);
        chk("s6_next_w", int'(ws[5:0]), 6'b100100);
        chk("s6_next_cnt", int'(frame_cnt), 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
